// File: rtl/lfsr_noise_bank_if.sv
// Control and sample bus of the LFSR noise bank.
// The master side drives step/seed/mode/window controls; the slave side returns samples.
interface lfsr_noise_bank_if #(
    parameter int unsigned LFSR_W = 24,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned N_CH   = 4
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    step;
    logic                    seed_we;
    logic [CH_W-1:0]         seed_ch;
    logic [LFSR_W-1:0]       seed_val;
    logic [N_CH-1:0]         mode;
    logic [N_CH*4-1:0]       shift_sel;
    logic [N_CH*OUT_W-1:0]   noise_out;
    logic                    out_valid;

    modport master (
        output step, seed_we, seed_ch, seed_val, mode, shift_sel,
        input  noise_out, out_valid
    );

    modport slave (
        input  step, seed_we, seed_ch, seed_val, mode, shift_sel,
        output noise_out, out_valid
    );
endinterface

// File: rtl/lfsr_noise_bank.sv
// Multi-channel Fibonacci LFSR noise source with optional moving-average smoothing
// and a per-channel output window. A step advances every channel; the selected
// samples are registered one edge later together with a one-cycle out_valid pulse.
module lfsr_noise_bank #(
    parameter int unsigned       LFSR_W   = 24,
    parameter int unsigned       OUT_W    = 16,
    parameter int unsigned       N_CH     = 4,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(24'hD80000),
    parameter int unsigned       SEED0    = 1,
    parameter int unsigned       AVG_LOG2 = 1
) (
    input logic               a_clk,
    input logic               reset_n,
    lfsr_noise_bank_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = LFSR_W + AVG_LOG2;
    localparam int unsigned MAX_S = LFSR_W - OUT_W;

    // Reset seed of a channel; an all-zero seed would lock the LFSR, so it becomes all ones.
    function automatic logic [LFSR_W-1:0] f_seed(int unsigned c);
        logic [LFSR_W-1:0] v;
        v = LFSR_W'(SEED0 + c);
        return (v == '0) ? '1 : v;
    endfunction

    logic [LFSR_W-1:0]        r_state [N_CH];
    logic [LFSR_W-1:0]        r_hist  [N_CH][DEPTH];  // [0] newest, [DEPTH-1] oldest
    logic signed [SUM_W-1:0]  r_sum   [N_CH];
    logic [OUT_W-1:0]         r_out   [N_CH];
    logic                     r_step;
    logic                     r_valid;

    logic [LFSR_W-1:0]        w_next     [N_CH];
    logic signed [SUM_W-1:0]  w_sum_next [N_CH];
    logic [LFSR_W-1:0]        w_avg      [N_CH];
    logic [LFSR_W-1:0]        w_src      [N_CH];
    int unsigned              w_sel      [N_CH];
    int unsigned              w_sh       [N_CH];
    logic [OUT_W-1:0]         w_win      [N_CH];
    logic [N_CH-1:0]          w_seed_hit;

    // Per-channel next state, running sum, source select and output window.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            // seed_ch values >= N_CH never match any channel and are thus ignored
            w_seed_hit[c] = bus.seed_we && (int'(bus.seed_ch) == c);
            if (r_state[c] == '0) begin
                w_next[c] = '1;
            end else begin
                w_next[c] = {r_state[c][LFSR_W-2:0], ^(r_state[c] & TAPS)};
            end
            w_sum_next[c] = r_sum[c] + SUM_W'(signed'(r_state[c]))
                                     - SUM_W'(signed'(r_hist[c][DEPTH-1]));
            w_avg[c] = LFSR_W'(r_sum[c] >>> AVG_LOG2);
            w_src[c] = bus.mode[c] ? w_avg[c] : r_hist[c][0];
            w_sel[c] = 32'(bus.shift_sel[4*c +: 4]);
            w_sh[c]  = (w_sel[c] > MAX_S) ? MAX_S : w_sel[c];
            w_win[c] = OUT_W'(w_src[c] >> w_sh[c]);
        end
    end

    // LFSR state, history FIFO, running sum and the step->output pipeline stage.
    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            r_step  <= 1'b0;
            r_valid <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= f_seed(c);
                r_sum[c]   <= '0;
                r_out[c]   <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_hist[c][d] <= '0;
                end
            end
        end else begin
            r_step  <= bus.step;
            r_valid <= r_step;
            for (int c = 0; c < N_CH; c++) begin
                // A seed write wins over a step on the same channel.
                if (w_seed_hit[c]) begin
                    r_state[c] <= (bus.seed_val == '0) ? '1 : bus.seed_val;
                    r_sum[c]   <= '0;
                    for (int d = 0; d < DEPTH; d++) begin
                        r_hist[c][d] <= '0;
                    end
                end else if (bus.step) begin
                    r_state[c]   <= w_next[c];
                    r_sum[c]     <= w_sum_next[c];
                    r_hist[c][0] <= r_state[c];
                    for (int d = 1; d < DEPTH; d++) begin
                        r_hist[c][d] <= r_hist[c][d-1];
                    end
                end
                if (r_step) begin
                    r_out[c] <= w_win[c];
                end
            end
        end
    end

    // Pack the registered samples onto the bus.
    always_comb begin
        bus.noise_out = '0;
        for (int c = 0; c < N_CH; c++) begin
            bus.noise_out[OUT_W*c +: OUT_W] = r_out[c];
        end
    end

    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_lfsr_noise_bank.sv
// Bench for lfsr_noise_bank: directed vector table, a full-period sequence on an
// 8-bit instance, and randomized traffic against a queue-based reference model.
module tb_lfsr_noise_bank;
    logic        clk;
    logic        reset_n;
    logic        step;
    logic        seed_we;
    logic [1:0]  seed_ch;
    logic [23:0] seed_val;
    logic [3:0]  mode;
    logic [15:0] shift_sel;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_noise_bank_if #(.LFSR_W(24), .OUT_W(16), .N_CH(4)) if_a ();
    lfsr_noise_bank_if #(.LFSR_W(8),  .OUT_W(4),  .N_CH(3)) if_b ();

    assign if_a.step      = step;
    assign if_a.seed_we   = seed_we;
    assign if_a.seed_ch   = seed_ch;
    assign if_a.seed_val  = seed_val;
    assign if_a.mode      = mode;
    assign if_a.shift_sel = shift_sel;
    assign if_b.step      = step;
    assign if_b.seed_we   = seed_we;
    assign if_b.seed_ch   = seed_ch;
    assign if_b.seed_val  = seed_val[7:0];
    assign if_b.mode      = mode[2:0];
    assign if_b.shift_sel = shift_sel[11:0];

    lfsr_noise_bank #(
        .LFSR_W(24), .OUT_W(16), .N_CH(4), .TAPS(24'hD80000), .SEED0(1), .AVG_LOG2(1)
    ) dut_a (
        .a_clk   (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    lfsr_noise_bank #(
        .LFSR_W(8), .OUT_W(4), .N_CH(3), .TAPS(8'hB8), .SEED0(1), .AVG_LOG2(0)
    ) dut_b (
        .a_clk   (clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instance 0 = dut_a, 1 = dut_b) ----------------
    longint m_state [2][4];
    longint m_hist  [2][4][$];  // front = newest pre-step state, always 2^AVG_LOG2 long
    longint m_out   [2][4];
    bit     m_valid [2];
    bit     m_step_prev;

    function automatic int w_of(int i);   return (i == 0) ? 24 : 8;  endfunction
    function automatic int ow_of(int i);  return (i == 0) ? 16 : 4;  endfunction
    function automatic int nc_of(int i);  return (i == 0) ? 4 : 3;   endfunction
    function automatic int al_of(int i);  return (i == 0) ? 1 : 0;   endfunction
    function automatic longint taps_of(int i);
        return (i == 0) ? 64'hD80000 : 64'hB8;
    endfunction
    function automatic longint mask_of(int i);
        return (64'sd1 <<< w_of(i)) - 1;
    endfunction

    function automatic longint sx(longint v, int w);
        if (((v >> (w - 1)) & 1) != 0) return v - (64'sd1 <<< w);
        return v;
    endfunction

    function automatic longint nz(longint v, longint mask);
        return (v == 0) ? mask : v;
    endfunction

    function automatic longint advance(int i, longint s);
        longint fb;
        if (s == 0) return mask_of(i);
        fb = longint'($countones(s & taps_of(i)) % 2);
        return ((s << 1) | fb) & mask_of(i);
    endfunction

    function automatic longint src_of(int i, int c);
        longint sum;
        longint d;
        longint avg;
        if (!mode[c]) return m_hist[i][c][0];
        sum = 0;
        d = 64'sd1 <<< al_of(i);
        for (int k = 0; k < m_hist[i][c].size(); k++) sum += sx(m_hist[i][c][k], w_of(i));
        if (sum >= 0) avg = sum / d;
        else avg = -((-sum + d - 1) / d);
        return avg & mask_of(i);
    endfunction

    function automatic void clear_hist(int i, int c);
        m_hist[i][c].delete();
        for (int k = 0; k < (1 << al_of(i)); k++) m_hist[i][c].push_back(0);
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_valid[i] = 1'b0;
                for (int c = 0; c < nc_of(i); c++) begin
                    m_state[i][c] = nz((1 + c) & mask_of(i), mask_of(i));
                    m_out[i][c] = 0;
                    clear_hist(i, c);
                end
            end else begin
                m_valid[i] = m_step_prev;
                for (int c = 0; c < nc_of(i); c++) begin
                    if (m_step_prev) begin
                        int s;
                        s = int'(shift_sel[4*c +: 4]);
                        if (s > w_of(i) - ow_of(i)) s = w_of(i) - ow_of(i);
                        m_out[i][c] = (src_of(i, c) >> s) & ((64'sd1 <<< ow_of(i)) - 1);
                    end
                end
                for (int c = 0; c < nc_of(i); c++) begin
                    if (seed_we && int'(seed_ch) == c) begin
                        m_state[i][c] = nz(longint'(seed_val) & mask_of(i), mask_of(i));
                        clear_hist(i, c);
                    end else if (step) begin
                        m_hist[i][c].push_front(m_state[i][c]);
                        void'(m_hist[i][c].pop_back());
                        m_state[i][c] = advance(i, m_state[i][c]);
                    end
                end
            end
        end
        m_step_prev = reset_n && step;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model at the edge, then compare both DUTs 1 time unit later.
    task automatic tick();
        logic [63:0] ea;
        logic [63:0] eb;
        @(posedge clk);
        model_edge();
        #1;
        ea = '0;
        eb = '0;
        for (int c = 0; c < 4; c++) ea[16*c +: 16] = 16'(m_out[0][c]);
        for (int c = 0; c < 3; c++) eb[4*c +: 4] = 4'(m_out[1][c]);
        check("model_a_valid", 64'(if_a.out_valid), 64'(m_valid[0]));
        check("model_a_noise", 64'(if_a.noise_out), ea);
        check("model_b_valid", 64'(if_b.out_valid), 64'(m_valid[1]));
        check("model_b_noise", 64'(if_b.noise_out), eb);
    endtask

    // ---------------- directed vector table (checked against dut_a) ----------------
    typedef struct {
        bit              r;
        bit              s;
        bit              we;
        logic [1:0]      ch;
        logic [23:0]     sv;
        logic [3:0]      md;
        logic [15:0]     sh;
        bit              ev;
        logic [3:0]      cm;
        logic [3:0][15:0] e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit s, bit we, logic [1:0] ch, logic [23:0] sv,
                               logic [3:0] md, logic [15:0] sh, bit ev, logic [3:0] cm,
                               logic [63:0] e);
        vec_t x;
        x.r = r; x.s = s; x.we = we; x.ch = ch; x.sv = sv;
        x.md = md; x.sh = sh; x.ev = ev; x.cm = cm; x.e = e;
        return x;
    endfunction

    int          first_ret;
    int          zeros;
    int          bad_v;
    logic [7:0]  st;

    initial begin
        reset_n = 1'b0; step = 1'b0; seed_we = 1'b0; seed_ch = '0;
        seed_val = '0; mode = '0; shift_sel = '0;

        //                 r  s  we ch  seed_val    md    shift     ev mask   expected ch3..ch0
        vecs.push_back(v(0, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'hF, 64'h0));
        vecs.push_back(v(0, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'hF, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h3, 64'h0002_0001));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h3, 64'h0004_0002));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h3, 64'h0004_0002));
        vecs.push_back(v(1, 0, 1, 1, 24'h800000, 4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0080, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0080, 1, 4'h2, 64'h8000_0000));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h2, 64'h0001_0000));
        vecs.push_back(v(1, 0, 1, 2, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0800, 1, 4'h4, 64'hFFFF_0000_0000));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h4, 64'hFFFE_0000_0000));
        vecs.push_back(v(1, 0, 1, 0, 24'h800000, 4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h1, 16'h0008, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h1, 16'h0008, 1, 4'h1, 64'hC000));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h1, 16'h0008, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h1, 16'h0008, 1, 4'h1, 64'hC000));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h1, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h1, 16'h0000, 1, 4'h1, 64'h0001));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h1, 64'h0001));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h0, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'h0, 64'h0));
        vecs.push_back(v(0, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'hF, 64'h0));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'hF, 64'h0));
        vecs.push_back(v(1, 1, 1, 3, 24'h00ABCD, 4'h0, 16'h0000, 1, 4'hF,
                         64'h0004_0003_0002_0001));
        vecs.push_back(v(1, 1, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'hF,
                         64'h0000_0006_0004_0002));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 1, 4'hF,
                         64'hABCD_000C_0008_0004));
        vecs.push_back(v(1, 0, 0, 0, 24'h0,      4'h0, 16'h0000, 0, 4'h0, 64'h0));

        foreach (vecs[n]) begin
            reset_n = vecs[n].r; step = vecs[n].s; seed_we = vecs[n].we;
            seed_ch = vecs[n].ch; seed_val = vecs[n].sv; mode = vecs[n].md;
            shift_sel = vecs[n].sh;
            tick();
            check($sformatf("vec%0d_valid", n), 64'(if_a.out_valid), 64'(vecs[n].ev));
            for (int c = 0; c < 4; c++) begin
                if (vecs[n].cm[c]) begin
                    check($sformatf("vec%0d_ch%0d", n, c), 64'(if_a.noise_out[16*c +: 16]),
                          64'(vecs[n].e[c]));
                end
            end
        end

        // Full-period run on the 8-bit instance: ch0 shows bits [3:0], ch1 (same seed) [7:4].
        reset_n = 1'b0; step = 1'b0; seed_we = 1'b0; mode = '0; shift_sel = '0;
        tick();
        reset_n = 1'b1; seed_we = 1'b1; seed_ch = 2'd1; seed_val = 24'h000001;
        tick();
        seed_we = 1'b0; step = 1'b1; shift_sel = 16'h0040;
        first_ret = -1; zeros = 0; bad_v = 0;
        for (int j = 0; j <= 256; j++) begin
            tick();
            if (j >= 1) begin
                st = {if_b.noise_out[7:4], if_b.noise_out[3:0]};
                if (if_b.out_valid !== 1'b1) bad_v++;
                if (st == 8'h00) zeros++;
                if (st == 8'h01 && j >= 2 && first_ret < 0) first_ret = j - 1;
            end
        end
        step = 1'b0;
        check("p8_period", 64'(first_ret), 64'(255));
        check("p8_never_zero", 64'(zeros), 64'(0));
        check("p8_continuous_valid", 64'(bad_v), 64'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset_n   = ($urandom_range(0, 149) != 0);
            step      = ($urandom_range(0, 2) != 0);
            seed_we   = ($urandom_range(0, 9) == 0);
            seed_ch   = 2'($urandom_range(0, 3));
            seed_val  = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
            mode      = 4'($urandom);
            shift_sel = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
